// File: rtl/aes_pkg.sv
// Shared definitions for the AES ciphertext output path: block type,
// words-per-block helper and the word ordering used on the output pins.
package aes_pkg;

  localparam int AES_BLK_W = 128;

  typedef logic [AES_BLK_W-1:0] aes_block_t;

  // Byte 0 of the AES state sits in bits [127:120], so MSW-first puts it on the pins first.
  localparam bit WORD_ORDER_MSW_FIRST = 1'b1;

  function automatic int words(input int word_w);
    return AES_BLK_W / word_w;
  endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// DEPTH x 128-bit block FIFO with pointers and occupancy count.
// A push is accepted when full only if a pop frees a slot in the same cycle.
module aes_blk_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [AES_BLK_W-1:0]   push_data_i,
  input  logic                   pop_i,
  output logic [AES_BLK_W-1:0]   head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  aes_block_t       mem_q [DEPTH];
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/aes_ct_serializer.sv
// Buffers aesEncCore cipherText blocks and streams them out MSW-first as
// WORD_W-bit words over valid/ready. Optional AES_CT_DROP_CNT_EN adds drop_count.
module aes_ct_serializer
  import aes_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ct_done,
  input  logic [AES_BLK_W-1:0] ct_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_W-1:0]    out_data,
  output logic                 out_last,
  output logic                 fifo_full,
  output logic                 overflow,
`ifdef AES_CT_DROP_CNT_EN
  output logic [15:0]          drop_count,
`endif
  input  logic                 clr_ovf
);

  localparam int NWORDS = words(WORD_W);
  localparam int WIDX_W = $clog2(NWORDS);
  localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(NWORDS - 1);

  logic [WIDX_W-1:0]      word_idx_q, word_idx_d;
  logic                   ovf_q, ovf_d;
  logic [AES_BLK_W-1:0]   head;
  logic [$clog2(DEPTH):0] blk_count;
  logic                   xfer;
  logic                   pop;
  logic                   drop;

  function automatic logic [WORD_W-1:0] sel_word(input logic [AES_BLK_W-1:0] blk,
                                                 input logic [WIDX_W-1:0]    idx);
    logic [WIDX_W-1:0]    pos;
    logic [AES_BLK_W-1:0] sh;
    pos = WORD_ORDER_MSW_FIRST ? idx : LAST_IDX - idx;
    sh  = blk << (int'(pos) * WORD_W);
    return sh[AES_BLK_W-1 -: WORD_W];
  endfunction

  aes_blk_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (ct_done),
    .push_data_i (ct_data),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (blk_count),
    .full_o      (fifo_full)
  );

  assign out_valid = (blk_count != '0);
  assign xfer      = out_valid && out_ready;
  assign pop       = xfer && (word_idx_q == LAST_IDX);
  assign drop      = ct_done && fifo_full && !pop;

  // Output word comes only from registered head and index; out_ready never reaches it.
  assign out_data = out_valid ? sel_word(head, word_idx_q) : '0;
  assign out_last = out_valid && (word_idx_q == LAST_IDX);
  assign overflow = ovf_q;

  always_comb begin
    word_idx_d = word_idx_q;
    if (xfer) word_idx_d = (word_idx_q == LAST_IDX) ? '0 : word_idx_q + 1'b1;
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_idx_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      word_idx_q <= word_idx_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef AES_CT_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clr_ovf)                          drop_cnt_d = drop ? 16'd1 : 16'd0;
    else if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule
